// File: rtl/neuron_input_packer_pkg.sv
// Shared types and constants for the Neuron layer datapath.
package nn_pkg;

  localparam int NN_W    = 8;
  localparam int NN_N_IN = 62;

  // Sign-magnitude activation: bit7 = sign, bits6:0 = magnitude.
  typedef struct packed {
    logic       sign;
    logic [6:0] mag;
  } sm8_t;

  // Negative zero carries no information for the neuron; fold it onto +0.
  function automatic sm8_t sm8_norm(input sm8_t x);
    sm8_t r;
    r = x;
    if (x.sign && (x.mag == 7'd0)) r = '0;
    return r;
  endfunction

endpackage

// File: rtl/neuron_input_packer_if.sv
// Handshake bundle between the activation stream source, the packer and the
// Neuron consumer. The packer uses the slave view; the stimulus side uses master.
interface neuron_input_packer_if #(
  parameter int N_IN = nn_pkg::NN_N_IN,
  parameter int W    = nn_pkg::NN_W
) ();
  import nn_pkg::*;

  logic              s_valid;
  logic              s_ready;
  logic [W-1:0]      s_data;
  logic              s_last;
  logic              m_valid;
  logic              m_ready;
  logic [N_IN*W-1:0] m_data;
  logic              frame_err;

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, frame_err
  );

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, frame_err
  );

endinterface

// File: rtl/neuron_input_packer.sv
// Packs a serial sign-magnitude activation stream into N_IN-wide vectors using
// two ping-pong banks: one fills while the other is held for the consumer.
module neuron_input_packer
  import nn_pkg::*;
#(
  parameter int N_IN          = NN_N_IN,
  parameter int W             = NN_W,
  parameter bit NORM_NEG_ZERO = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  neuron_input_packer_if.slave   bus
);

  localparam int CW = $clog2(N_IN);
  localparam int VW = N_IN * W;
  localparam logic [CW-1:0] LAST_IDX = CW'(N_IN - 1);

  logic [VW-1:0] bank_q [2];
  logic [VW-1:0] bank_d [2];
  logic [1:0]    full_q, full_d;
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [CW-1:0] count_q, count_d;
  logic          frame_err_q, frame_err_d;
  // Holds s_ready low until the first edge after reset is released.
  logic          run_q, run_d;

  logic          s_ready;
  logic          accept;
  logic          drain;
  logic          is_end;
  logic          close;
  logic [W-1:0]  elem;

  // s_ready depends only on registered state, keeping m_ready off the input path.
  assign s_ready = run_q & ~full_q[wr_bank_q];
  assign accept  = bus.s_valid & s_ready;
  assign drain   = full_q[rd_bank_q] & bus.m_ready;
  assign is_end  = (count_q == LAST_IDX);
  assign close   = accept & (bus.s_last | is_end);

  // Next-state: element capture, frame close/padding, and consumer drain.
  always_comb begin
    bank_d      = bank_q;
    full_d      = full_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    count_d     = count_q;
    frame_err_d = 1'b0;
    run_d       = 1'b1;

    elem = bus.s_data;
    if (NORM_NEG_ZERO) elem = sm8_norm(sm8_t'(bus.s_data));

    if (accept) begin
      bank_d[wr_bank_q][int'(count_q)*W +: W] = elem;
      // Short frame: pad the unwritten tail so stale data from the previous
      // use of this bank never reaches the neuron.
      if (bus.s_last && !is_end) begin
        for (int i = 0; i < N_IN; i++) begin
          if (i > int'(count_q)) bank_d[wr_bank_q][i*W +: W] = '0;
        end
      end
      if (bus.s_last != is_end) frame_err_d = 1'b1;
      if (close) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        count_d           = '0;
      end else begin
        count_d = count_q + 1'b1;
      end
    end

    // Accept and drain can never target the same bank: accept needs it empty,
    // drain needs it full.
    if (drain) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_q[0]   <= '0;
      bank_q[1]   <= '0;
      full_q      <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      count_q     <= '0;
      frame_err_q <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      bank_q[0]   <= bank_d[0];
      bank_q[1]   <= bank_d[1];
      full_q      <= full_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      count_q     <= count_d;
      frame_err_q <= frame_err_d;
      run_q       <= run_d;
    end
  end

  assign bus.s_ready   = s_ready;
  assign bus.m_valid   = full_q[rd_bank_q];
  assign bus.m_data    = bank_q[rd_bank_q];
  assign bus.frame_err = frame_err_q;

endmodule
